// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative multiply/divide unit: operation codes,
// FSM state codes and default datapath sizing.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_ITER  = MD_WIDTH;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'b00;
  localparam state_t ST_RUN  = 2'b01;
  localparam state_t ST_FIX  = 2'b10;

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the core's register-file path and the
// multiply/divide unit.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, mthi, mtlo,
                  input  busy, done, hi, lo);
  modport slave  (input  start, op, a, b, mthi, mtlo,
                  output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply (mode 0), restoring
// trial-subtract-shift for divide (mode 1), over a 2*WIDTH accumulator.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic               div_mode_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] trial_s;
  logic           fits_s;

  // Multiply keeps the multiplier in the low half; divide keeps the
  // remainder high and the dividend/quotient bits low.
  always_comb begin
    sum_s     = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, opnd_i};
    shifted_s = acc_i[2*WIDTH-1:WIDTH-1];
    trial_s   = shifted_s - {1'b0, opnd_i};
    fits_s    = ~trial_s[WIDTH];
    if (div_mode_i) begin
      acc_o = {(fits_s ? trial_s[WIDTH-1:0] : shifted_s[WIDTH-1:0]),
               acc_i[WIDTH-2:0], fits_s};
    end else if (acc_i[0]) begin
      acc_o = {sum_s, acc_i[WIDTH-1:1]};
    end else begin
      acc_o = {1'b0, acc_i[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers: magnitude datapath,
// sign fix-up on exit, and mthi/mtlo moves while idle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int ITER  = WIDTH
) (
  input  logic      clk,
  input  logic      rst_n,
  muldiv_if.slave   bus
);

  localparam int CW = $clog2(ITER + 1);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               dz_q, dz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               sgn_s;
  logic [WIDTH-1:0]   a_abs_s;
  logic [WIDTH-1:0]   b_abs_s;
  logic [2*WIDTH-1:0] step_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quot_s;
  logic [WIDTH-1:0]   rem_s;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_mode_i (is_div_q),
    .acc_i      (acc_q),
    .opnd_i     (opnd_q),
    .acc_o      (step_s)
  );

  // Operand magnitudes at accept, sign-corrected results at commit.
  always_comb begin
    sgn_s   = ~bus.op[0];
    a_abs_s = (sgn_s && bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
    b_abs_s = (sgn_s && bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;
    prod_s  = neg_lo_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
    quot_s  = neg_lo_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
    rem_s   = neg_hi_q ? (~acc_q[2*WIDTH-1:WIDTH] + WIDTH'(1))
                       : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state logic for the IDLE -> RUN -> FIX sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          is_div_d = bus.op[1];
          acc_d    = {{WIDTH{1'b0}}, (bus.op[1] ? a_abs_s : b_abs_s)};
          opnd_d   = bus.op[1] ? b_abs_s : a_abs_s;
          neg_lo_d = sgn_s & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          neg_hi_d = sgn_s & bus.a[WIDTH-1];
          dz_d     = (bus.b == {WIDTH{1'b0}});
          cnt_d    = CW'(ITER);
          busy_d   = 1'b1;
          state_d  = ST_RUN;
        end else begin
          hi_d = bus.mthi ? bus.a : hi_q;
          lo_d = bus.mtlo ? bus.a : lo_q;
        end
      end
      ST_RUN: begin
        acc_d   = step_s;
        cnt_d   = cnt_q - CW'(1);
        state_d = (cnt_q == CW'(1)) ? ST_FIX : ST_RUN;
      end
      ST_FIX: begin
        if (is_div_q) begin
          hi_d = rem_s;
          lo_d = dz_q ? {WIDTH{1'b1}} : quot_s;
        end else begin
          hi_d = prod_s[2*WIDTH-1:WIDTH];
          lo_d = prod_s[WIDTH-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CW{1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      opnd_q   <= {WIDTH{1'b0}};
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit with hand-computed HI/LO results.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk;
  logic rst_n;
  int   vec_cnt;
  int   err_cnt;

  muldiv_if #(.WIDTH(32)) bus_if ();

  muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Launch one operation, optionally poke a rogue multu start mid-run,
  // then check latency, busy length and the committed HI/LO.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int poke_at);
    int n;
    int busy_n;
    bus_if.start = 1'b1;
    bus_if.op    = op;
    bus_if.a     = a;
    bus_if.b     = b;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    busy_n = bus_if.busy ? 1 : 0;
    n = 0;
    while (!bus_if.done && n < 100) begin
      if (poke_at > 0 && n == poke_at) begin
        bus_if.start = 1'b1;
        bus_if.op    = OP_MULTU;
        bus_if.a     = 32'd3;
        bus_if.b     = 32'd5;
      end
      @(posedge clk); #1;
      bus_if.start = 1'b0;
      n++;
      if (bus_if.busy) busy_n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd33);
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'd33);
    chk({tag, "_hi"}, {32'd0, bus_if.hi}, {32'd0, exp_hi});
    chk({tag, "_lo"}, {32'd0, bus_if.lo}, {32'd0, exp_lo});
  endtask

  initial begin
    int done_seen;
    vec_cnt = 0;
    err_cnt = 0;
    rst_n        = 1'b0;
    bus_if.start = 1'b0;
    bus_if.op    = 2'b00;
    bus_if.a     = 32'd0;
    bus_if.b     = 32'd0;
    bus_if.mthi  = 1'b0;
    bus_if.mtlo  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, bus_if.busy}, 64'd0);
    chk("rst_done", {63'd0, bus_if.done}, 64'd0);
    chk("rst_hi", {32'd0, bus_if.hi}, 64'd0);
    chk("rst_lo", {32'd0, bus_if.lo}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("mult_neg3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
    chk("mult_done_pulse", {63'd0, bus_if.done}, 64'd1);
    @(posedge clk); #1;
    chk("done_one_cycle", {63'd0, bus_if.done}, 64'd0);
    chk("busy_after_fix", {63'd0, bus_if.busy}, 64'd0);

    run_op("multu_ones", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    run_op("mult_ones", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 0);
    run_op("div_neg7by2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);
    run_op("divu_100by7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0);
    run_op("divu_by0", OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 0);
    run_op("div_neg10by0", OP_DIV, 32'hFFFF_FFF6, 32'd0, 32'hFFFF_FFF6, 32'hFFFF_FFFF, 0);

    // Rogue start mid-divu, then a back-to-back start in the done cycle.
    run_op("divu_poked", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 5);
    run_op("b2b_multu", OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 0);

    bus_if.mthi = 1'b1;
    bus_if.a    = 32'h1234_5678;
    @(posedge clk); #1;
    bus_if.mthi = 1'b0;
    chk("mthi_hi", {32'd0, bus_if.hi}, 64'h1234_5678);
    chk("mthi_lo_kept", {32'd0, bus_if.lo}, 64'd15);
    bus_if.mtlo = 1'b1;
    bus_if.a    = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    bus_if.mtlo = 1'b0;
    chk("mtlo_lo", {32'd0, bus_if.lo}, 64'h9ABC_DEF0);
    chk("mtlo_hi_kept", {32'd0, bus_if.hi}, 64'h1234_5678);
    chk("move_no_done", {63'd0, bus_if.done}, 64'd0);
    bus_if.mthi = 1'b1;
    bus_if.mtlo = 1'b1;
    bus_if.a    = 32'hCAFE_0001;
    @(posedge clk); #1;
    bus_if.mthi = 1'b0;
    bus_if.mtlo = 1'b0;
    chk("mvboth_hi", {32'd0, bus_if.hi}, 64'hCAFE_0001);
    chk("mvboth_lo", {32'd0, bus_if.lo}, 64'hCAFE_0001);

    // Start with a move in the same cycle: start wins, HI/LO hold.
    bus_if.start = 1'b1;
    bus_if.mthi  = 1'b1;
    bus_if.op    = OP_MULT;
    bus_if.a     = 32'd5;
    bus_if.b     = 32'd6;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    bus_if.mthi  = 1'b0;
    chk("start_beats_mthi", {32'd0, bus_if.hi}, 64'hCAFE_0001);
    chk("start_busy", {63'd0, bus_if.busy}, 64'd1);
    repeat (9) @(posedge clk);
    #1;
    chk("run_hi_held", {32'd0, bus_if.hi}, 64'hCAFE_0001);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_busy", {63'd0, bus_if.busy}, 64'd0);
    chk("abort_done", {63'd0, bus_if.done}, 64'd0);
    chk("abort_hi", {32'd0, bus_if.hi}, 64'd0);
    chk("abort_lo", {32'd0, bus_if.lo}, 64'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus_if.done || bus_if.busy) done_seen++;
    end
    chk("abort_quiet", 64'(done_seen), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
